// File: rtl/fifo_rd_bridge_pkg.sv
// rtl/fifo_rd_bridge_pkg.sv - shared sync FIFO / read bridge parameters and types
package fifo_rd_bridge_pkg;

  localparam int SYNC_FIFO_DATA_WIDTH = 3;
  localparam int SYNC_FIFO_DEPTH      = 16;
  localparam int BUF_DEPTH            = 2;
  localparam int OCC_W                = $clog2(BUF_DEPTH + 1);

  typedef logic [OCC_W-1:0] occ_t;
  typedef logic [OCC_W:0]   lvl_t;

  localparam occ_t OCC_ONE  = occ_t'(1);
  localparam occ_t OCC_FULL = occ_t'(BUF_DEPTH);
  localparam lvl_t LVL_FULL = lvl_t'(BUF_DEPTH);

  // Words committed to the bridge: buffered plus the one still in flight.
  function automatic lvl_t level(input occ_t occ, input logic inflight);
    return {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
  endfunction

endpackage

// File: rtl/fifo_rd_bridge_buf.sv
// rtl/fifo_rd_bridge_buf.sv - rd_skid_buf: 2-entry in-order word store (push/pop/head/occ)
module rd_skid_buf
  import fifo_rd_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = SYNC_FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output occ_t                  occ_o
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
  occ_t                  occ_q;
  occ_t                  occ_d;
  logic                  do_pop;

  assign do_pop = pop_i && (occ_q != '0);

  // Pop shifts first, so a same-cycle push lands behind whatever remains.
  always_comb begin
    mem_d = mem_q;
    occ_d = occ_q;
    if (do_pop) begin
      mem_d[0] = mem_q[1];
      occ_d    = occ_q - OCC_ONE;
    end
    if (push_i && (occ_d != OCC_FULL)) begin
      if (occ_d == '0) begin
        mem_d[0] = data_i;
      end else begin
        mem_d[1] = data_i;
      end
      occ_d = occ_d + OCC_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      occ_q <= occ_d;
      mem_q <= mem_d;
    end
  end

  assign head_o = mem_q[0];
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_rd_bridge.sv
// rtl/fifo_rd_bridge.sv - registered-read FIFO to valid/ready stream bridge
// Optional transfer counter output xfer_cnt when FIFO_RD_BRIDGE_XFER_CNT_EN is defined.
module fifo_rd_bridge
  import fifo_rd_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = SYNC_FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_date,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_RD_BRIDGE_XFER_CNT_EN
  ,
  output logic [15:0]           xfer_cnt
`endif
);

  logic inflight_q;
  logic inflight_d;
  occ_t occ;
  lvl_t lvl;
  logic xfer;

  assign m_valid = (occ != '0);
  assign xfer    = m_valid && m_ready;
  assign lvl     = level(occ, inflight_q);

  // Gated by rst_n so no read is requested while the FIFO is held in reset.
  always_comb begin
    fifo_rd_en = rst_n && !fifo_empty &&
                 ((lvl < LVL_FULL) || (xfer && (lvl == LVL_FULL)));
    inflight_d = fifo_rd_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (inflight_q),
    .data_i (fifo_rd_date),
    .pop_i  (xfer),
    .head_o (m_data),
    .occ_o  (occ)
  );

`ifdef FIFO_RD_BRIDGE_XFER_CNT_EN
  logic [15:0] xfer_cnt_q;
  logic [15:0] xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (xfer) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= 16'd0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_bridge.sv
// tb/tb_fifo_rd_bridge.sv - self-checking bench for fifo_rd_bridge
module tb_fifo_rd_bridge;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_date;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
`ifdef FIFO_RD_BRIDGE_XFER_CNT_EN
  logic [15:0]   xfer_cnt;
`endif

  fifo_rd_bridge #(
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_date (fifo_rd_date),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready)
`ifdef FIFO_RD_BRIDGE_XFER_CNT_EN
    ,
    .xfer_cnt     (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: source FIFO contents, words held by the bridge, one in-flight read.
  logic [DW-1:0] src_q [$];
  logic [DW-1:0] mbuf [$];
  bit            minfl;
  logic [DW-1:0] mrd_word;
  int            mcnt;
  logic [DW-1:0] next_word;

  bit            s_valid;
  bit            s_rd;
  bit            s_ready;
  logic [DW-1:0] s_data;
  int            dut_reads;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    mbuf.delete();
    src_q.delete();
    minfl = 1'b0;
    mcnt  = 0;
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    clear_model();
    fifo_empty = 1'b1;
    m_ready    = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    dut_reads = 0;
  endtask

  // push_mode: 0 none, 1 random, 2 one word every cycle
  task automatic step(input bit nxt_ready, input int push_mode);
    bit pop;
    bit e_rd;
    int lvl;
    @(negedge clk);
    lvl  = mbuf.size() + int'(minfl);
    pop  = (mbuf.size() != 0) && m_ready;
    e_rd = !fifo_empty && ((lvl < 2) || (pop && lvl == 2));
    s_valid = m_valid;
    s_data  = m_data;
    s_rd    = fifo_rd_en;
    s_ready = m_ready;
    if (s_rd) dut_reads++;
    check("m_valid", 32'(m_valid), 32'(mbuf.size() != 0));
    if (mbuf.size() != 0) check("m_data", 32'(m_data), 32'(mbuf[0]));
    check("fifo_rd_en", 32'(fifo_rd_en), 32'(e_rd));
`ifdef FIFO_RD_BRIDGE_XFER_CNT_EN
    check("xfer_cnt", 32'(xfer_cnt), 32'(mcnt % 65536));
`endif
    @(posedge clk);
    #1;
    if (pop) begin
      void'(mbuf.pop_front());
      mcnt++;
    end
    if (minfl) mbuf.push_back(mrd_word);
    minfl = e_rd;
    if (e_rd && src_q.size() != 0) begin
      mrd_word     = src_q.pop_front();
      fifo_rd_date = mrd_word;
    end else begin
      fifo_rd_date = DW'($urandom);
    end
    if (push_mode == 2 || (push_mode == 1 && $urandom_range(0, 1) == 1)) begin
      src_q.push_back(next_word);
      next_word = next_word + 1'b1;
    end
    fifo_empty = (src_q.size() == 0);
    m_ready    = nxt_ready;
  endtask

  logic [DW-1:0] got_q [$];
  bit            seen;

  initial begin
    rst_n        = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_date = '0;
    m_ready      = 1'b0;
    next_word    = 8'h40;
    dut_reads    = 0;
    clear_model();

    // Reset held with a non-empty FIFO, then 1..5 streamed at full rate
    for (int w = 1; w <= 5; w++) src_q.push_back(DW'(w));
    fifo_empty = 1'b0;
    m_ready    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_data", 32'(m_data), 32'd0);
`ifdef FIFO_RD_BRIDGE_XFER_CNT_EN
      check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
`endif
    end
    release_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 0);
      check("s027_valid", 32'(s_valid), 32'(i >= 2 && i <= 6));
      if (i >= 2 && i <= 6) check("s027_data", 32'(s_data), 32'(i - 1));
    end

    // Stalled sink: only two reads, head held
    hard_reset();
    for (int w = 0; w < 8; w++) src_q.push_back(DW'(8'h10 + w));
    fifo_empty = 1'b0;
    release_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 0);
    check("s028_reads", 32'(dut_reads), 32'd2);
    check("s028_rd_en", 32'(s_rd), 32'd0);
    check("s028_valid", 32'(s_valid), 32'd1);
    check("s028_head", 32'(s_data), 32'h10);
    for (int i = 0; i < 20; i++) step(1'b1, 0);

    // m_ready alternating 1,0,1,0 against a full FIFO
    hard_reset();
    for (int w = 0; w < 8; w++) src_q.push_back(DW'(8'h20 + w));
    fifo_empty = 1'b0;
    m_ready    = 1'b1;
    release_reset();
    got_q.delete();
    for (int i = 0; i < 24; i++) begin
      step(((i + 1) % 2) == 0, 0);
      if (s_valid && s_ready) got_q.push_back(s_data);
    end
    check("s029_count", 32'(got_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < got_q.size(); k++) begin
      check("s029_order", 32'(got_q[k]), 32'(8'h20 + k));
    end

    // Reset pulsed while a read is in flight and a word is buffered
    hard_reset();
    for (int w = 0; w < 6; w++) src_q.push_back(DW'(8'h30 + w));
    fifo_empty = 1'b0;
    release_reset();
    step(1'b0, 0);
    step(1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("s030_valid", 32'(m_valid), 32'd0);
    check("s030_rd_en", 32'(fifo_rd_en), 32'd0);
    check("s030_data", 32'(m_data), 32'd0);
    clear_model();
    fifo_empty = 1'b1;
    m_ready    = 1'b1;
    repeat (2) @(posedge clk);
    release_reset();
    step(1'b1, 0);
    for (int w = 0; w < 4; w++) src_q.push_back(DW'(8'hA0 + w));
    fifo_empty = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 0);
      if (s_valid && !seen) begin
        seen = 1'b1;
        check("s030_first", 32'(s_data), 32'hA0);
      end
    end
    check("s030_seen", 32'(seen), 32'd1);

    // Random sink stalls with random source arrivals
    hard_reset();
    release_reset();
    for (int i = 0; i < 400; i++) step($urandom_range(0, 3) != 0, 1);
    for (int i = 0; i < 600 && (src_q.size() != 0 || mbuf.size() != 0 || minfl); i++) begin
      step(1'b1, 0);
    end
    step(1'b1, 0);
    check("rand_drained", 32'(s_valid), 32'd0);

`ifdef FIFO_RD_BRIDGE_XFER_CNT_EN
    hard_reset();
    m_ready = 1'b1;
    release_reset();
    for (int i = 0; i < 70000 && mcnt < 65537; i++) step(1'b1, 2);
    @(negedge clk);
    check("xfer_65537", 32'(xfer_cnt), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
